// File: rtl/matmul_sequencer.sv
// Responder for the start_mat_mul/done_mat_mul handshake: sequences clear, A/B feed,
// pipeline drain and C store for each systolic-array tile.
module matmul_sequencer #(
  parameter int DIM    = 4,
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_mat_mul,
  input  logic [CNT_W-1:0]  num_tiles,
  input  logic [ADDR_W-1:0] a_base,
  input  logic [ADDR_W-1:0] b_base,
  input  logic [ADDR_W-1:0] c_base,
  output logic              clear_acc,
  output logic              a_rd_en,
  output logic [ADDR_W-1:0] a_addr,
  output logic              b_rd_en,
  output logic [ADDR_W-1:0] b_addr,
  output logic              c_wr_en,
  output logic [ADDR_W-1:0] c_addr,
  output logic              busy,
  output logic              done_mat_mul
);

  localparam int PH_W = $clog2(2*DIM);

  typedef enum logic [2:0] {IDLE, CLEAR, LOAD, DRAIN, STORE, DONE} state_t;

  state_t            state, state_next;
  logic [PH_W-1:0]   phase;
  logic [CNT_W-1:0]  tile, num_tiles_r;
  logic [ADDR_W-1:0] a_base_r, b_base_r, c_base_r, tile_off;
  logic [ADDR_W-1:0] a_addr_r, b_addr_r, c_addr_r;
  logic              last_tile;

  assign last_tile = (tile == num_tiles_r - CNT_W'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Dropping start in any working state aborts straight back to IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (start_mat_mul) state_next = (num_tiles == '0) ? DONE : CLEAR;
      CLEAR: state_next = start_mat_mul ? LOAD : IDLE;
      LOAD: begin
        if (!start_mat_mul)                state_next = IDLE;
        else if (phase == PH_W'(DIM-1))    state_next = DRAIN;
      end
      DRAIN: begin
        if (!start_mat_mul)                state_next = IDLE;
        else if (phase == PH_W'(2*DIM-2))  state_next = STORE;
      end
      STORE: begin
        if (!start_mat_mul)                state_next = IDLE;
        else if (phase == PH_W'(DIM-1))    state_next = last_tile ? DONE : CLEAR;
      end
      DONE:  if (!start_mat_mul) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Address registers are loaded on phase entry so outputs never depend on live inputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase       <= '0;
      tile        <= '0;
      num_tiles_r <= '0;
      a_base_r    <= '0;
      b_base_r    <= '0;
      c_base_r    <= '0;
      tile_off    <= '0;
      a_addr_r    <= '0;
      b_addr_r    <= '0;
      c_addr_r    <= '0;
    end else begin
      if (state_next != state || state == IDLE || state == DONE) phase <= '0;
      else                                                      phase <= phase + PH_W'(1);
      case (state)
        IDLE: if (start_mat_mul) begin
          num_tiles_r <= num_tiles;
          a_base_r    <= a_base;
          b_base_r    <= b_base;
          c_base_r    <= c_base;
          tile        <= '0;
          tile_off    <= '0;
        end
        CLEAR: if (state_next == LOAD) begin
          a_addr_r <= a_base_r + tile_off;
          b_addr_r <= b_base_r + tile_off;
        end
        LOAD: if (state_next == LOAD) begin
          a_addr_r <= a_addr_r + ADDR_W'(1);
          b_addr_r <= b_addr_r + ADDR_W'(1);
        end
        DRAIN: if (state_next == STORE) c_addr_r <= c_base_r + tile_off;
        STORE: begin
          if (state_next == STORE) c_addr_r <= c_addr_r + ADDR_W'(1);
          else if (state_next == CLEAR) begin
            tile     <= tile + CNT_W'(1);
            tile_off <= tile_off + ADDR_W'(DIM);
          end
        end
        default: ;
      endcase
    end
  end

  assign clear_acc    = (state == CLEAR);
  assign a_rd_en      = (state == LOAD);
  assign b_rd_en      = (state == LOAD);
  assign c_wr_en      = (state == STORE);
  assign busy         = (state != IDLE) && (state != DONE);
  assign done_mat_mul = (state == DONE);
  assign a_addr       = a_addr_r;
  assign b_addr       = b_addr_r;
  assign c_addr       = c_addr_r;

endmodule

// File: tb/tb_matmul_sequencer.sv
// Scoreboard bench for matmul_sequencer: expected clear/read/write events are queued
// when a run is started and matched against the DUT as they appear.
module tb_matmul_sequencer;

  localparam int DIM    = 4;
  localparam int ADDR_W = 10;
  localparam int CNT_W  = 8;
  localparam int MASK   = (1 << ADDR_W) - 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              start_mat_mul;
  logic [CNT_W-1:0]  num_tiles;
  logic [ADDR_W-1:0] a_base, b_base, c_base;
  logic              clear_acc, a_rd_en, b_rd_en, c_wr_en, busy, done_mat_mul;
  logic [ADDR_W-1:0] a_addr, b_addr, c_addr;

  typedef struct { int cyc; int a; int b; } rd_ev_t;
  typedef struct { int cyc; int c; } wr_ev_t;

  int     clr_q[$];
  rd_ev_t rd_q[$];
  wr_ev_t wr_q[$];

  int cyc = 0;
  int start_cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  matmul_sequencer #(.DIM(DIM), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start_mat_mul(start_mat_mul), .num_tiles(num_tiles),
    .a_base(a_base), .b_base(b_base), .c_base(c_base), .clear_acc(clear_acc),
    .a_rd_en(a_rd_en), .a_addr(a_addr), .b_rd_en(b_rd_en), .b_addr(b_addr),
    .c_wr_en(c_wr_en), .c_addr(c_addr), .busy(busy), .done_mat_mul(done_mat_mul)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Match every enable pulse against the head of its queue, on the falling edge
  always @(negedge clk) begin
    int     rel;
    rd_ev_t re;
    wr_ev_t we;
    if (!reset) begin
      rel = cyc - start_cyc + 1;
      if ((int'(clear_acc) + int'(a_rd_en) + int'(c_wr_en)) > 1)
        checkOutput("exclusive", int'(clear_acc) + int'(a_rd_en) + int'(c_wr_en), 1);
      if (clear_acc) begin
        if (clr_q.size() == 0) checkOutput("clr_unexpected", rel, -1);
        else                   checkOutput("clr_cycle", rel, clr_q.pop_front());
      end
      if (a_rd_en) begin
        if (rd_q.size() == 0) checkOutput("rd_unexpected", rel, -1);
        else begin
          re = rd_q.pop_front();
          checkOutput("rd_cycle", rel, re.cyc);
          checkOutput("a_addr", int'(a_addr), re.a);
          checkOutput("b_addr", int'(b_addr), re.b);
          checkOutput("b_rd_en", int'(b_rd_en), 1);
        end
      end
      if (c_wr_en) begin
        if (wr_q.size() == 0) checkOutput("wr_unexpected", rel, -1);
        else begin
          we = wr_q.pop_front();
          checkOutput("wr_cycle", rel, we.cyc);
          checkOutput("c_addr", int'(c_addr), we.c);
        end
      end
    end
  end

  // Queue the expected events, raise start and scramble inputs after they are sampled
  task automatic applyStimulus(input int n, input int a, input int b, input int c,
                               input bit with_store);
    rd_ev_t re;
    wr_ev_t we;
    num_tiles = CNT_W'(n);
    a_base    = ADDR_W'(a);
    b_base    = ADDR_W'(b);
    c_base    = ADDR_W'(c);
    for (int t = 0; t < n; t++) begin
      clr_q.push_back(1 + 4*DIM*t);
      for (int k = 0; k < DIM; k++) begin
        re.cyc = 2 + 4*DIM*t + k;
        re.a   = (a + t*DIM + k) & MASK;
        re.b   = (b + t*DIM + k) & MASK;
        rd_q.push_back(re);
        if (with_store) begin
          we.cyc = 3*DIM + 1 + 4*DIM*t + k;
          we.c   = (c + t*DIM + k) & MASK;
          wr_q.push_back(we);
        end
      end
    end
    start_mat_mul = 1'b1;
    @(posedge clk);
    #1;
    start_cyc = cyc;
    num_tiles = 8'hA7;
    a_base    = 10'h155;
    b_base    = 10'h2AA;
    c_base    = 10'h0F0;
  endtask

  task automatic checkQueuesEmpty(input string tag);
    checkOutput({tag, "_clr_left"}, clr_q.size(), 0);
    checkOutput({tag, "_rd_left"}, rd_q.size(), 0);
    checkOutput({tag, "_wr_left"}, wr_q.size(), 0);
  endtask

  // Wait (bounded) for done, then verify it holds and drops after start is released
  task automatic finishRun(input string tag, input int exp_rel);
    int rel;
    rel = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done_mat_mul) begin
        rel = cyc - start_cyc + 1;
        break;
      end
    end
    checkOutput({tag, "_done_cycle"}, rel, exp_rel);
    repeat (2) @(negedge clk);
    checkOutput({tag, "_done_hold"}, int'(done_mat_mul), 1);
    checkOutput({tag, "_busy_in_done"}, int'(busy), 0);
    start_mat_mul = 1'b0;
    @(negedge clk);
    checkOutput({tag, "_done_drop"}, int'(done_mat_mul), 0);
    checkQueuesEmpty(tag);
  endtask

  initial begin
    int done_seen;
    reset         = 1'b1;
    start_mat_mul = 1'b0;
    num_tiles     = '0;
    a_base        = '0;
    b_base        = '0;
    c_base        = '0;
    #12;
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_done", int'(done_mat_mul), 0);
    checkOutput("rst_enables", int'({clear_acc, a_rd_en, b_rd_en, c_wr_en}), 0);
    checkOutput("rst_addrs", int'({a_addr, b_addr, c_addr}), 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // single tile
    applyStimulus(1, 'h10, 'h20, 'h30, 1'b1);
    finishRun("one_tile", 17);

    // three tiles back to back, restart right after returning to IDLE
    applyStimulus(3, 0, 0, 0, 1'b1);
    finishRun("three_tiles", 49);

    // zero tiles goes straight to DONE
    applyStimulus(0, 'h40, 'h50, 'h60, 1'b1);
    finishRun("zero_tiles", 1);

    // abort during drain of tile 0
    applyStimulus(1, 'h10, 'h20, 'h30, 1'b0);
    repeat (8) @(negedge clk);
    start_mat_mul = 1'b0;
    @(negedge clk);
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_enables", int'({clear_acc, a_rd_en, c_wr_en}), 0);
    done_seen = 0;
    repeat (20) begin
      @(negedge clk);
      done_seen += int'(done_mat_mul);
    end
    checkOutput("abort_no_done", done_seen, 0);
    checkQueuesEmpty("abort");

    // asynchronous reset in the middle of LOAD
    applyStimulus(1, 'h10, 'h20, 'h30, 1'b1);
    repeat (3) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("midrst_enables", int'({clear_acc, a_rd_en, b_rd_en, c_wr_en}), 0);
    checkOutput("midrst_busy", int'(busy), 0);
    checkOutput("midrst_done", int'(done_mat_mul), 0);
    checkOutput("midrst_addrs", int'({a_addr, b_addr, c_addr}), 0);
    start_mat_mul = 1'b0;
    clr_q.delete();
    rd_q.delete();
    wr_q.delete();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    applyStimulus(1, 'h10, 'h20, 'h30, 1'b1);
    finishRun("after_rst", 17);

    // A address wraps around the top of the SRAM
    applyStimulus(1, MASK - 1, 'h100, 'h200, 1'b1);
    finishRun("wrap", 17);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not complete, %0d tests run", n_tests);
    $fatal(1);
  end

endmodule
